// File: rtl/mul_hash_lookup_pkg.sv
// Shared widths, default latencies, result/probe records and hash field extractors for the lookup path.
package mul_hash_lookup_pkg;

  localparam int HASH_LAT_DEF   = 10;
  localparam int RAM_LAT_DEF    = 2;
  localparam int IDX_W          = 12;
  localparam int FP_W           = 16;
  localparam int TAG_W          = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             hit;
  } lookup_res_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [FP_W-1:0]  fp;
  } probe_t;

  function automatic logic [FP_W-1:0] fp_of(input logic [63:0] hash);
    return hash[FP_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [63:0] hash);
    return hash[63 -: IDX_W];
  endfunction

endpackage

// File: rtl/mul_hash_lookup_if.sv
// Request (key/tag) and result (tag/idx/hit) valid-ready streams of the lookup block.
interface mul_hash_lookup_if;
  import mul_hash_lookup_pkg::*;

  logic [63:0]      s_key;
  logic [TAG_W-1:0] s_tag;
  logic             s_valid;
  logic             s_ready;
  logic [TAG_W-1:0] m_tag;
  logic [IDX_W-1:0] m_idx;
  logic             m_hit;
  logic             m_valid;
  logic             m_ready;

  modport master (
    output s_key, s_tag, s_valid, m_ready,
    input  s_ready, m_tag, m_idx, m_hit, m_valid
  );

  modport slave (
    input  s_key, s_tag, s_valid, m_ready,
    output s_ready, m_tag, m_idx, m_hit, m_valid
  );

endinterface

// File: rtl/mul_hash_lookup_res_fifo.sv
// First-word-fall-through result FIFO; head is visible the cycle after the push, push and pop may coincide at any fill level.
module lookup_res_fifo
  import mul_hash_lookup_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  lookup_res_t            push_dat,
  input  logic                   pop,
  output lookup_res_t            head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  lookup_res_t   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  // Storage is reset so the result outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_dat;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mul_hash_lookup.sv
// Issues keys to the external hash pipe, reads the bucket RAM and emits tagged hit/miss results; accept-to-m_valid is 14 cycles.
// Admission is credit based (one credit per FIFO entry) so the non-stallable hash/RAM path can never overflow the result FIFO.
module mul_hash_lookup
  import mul_hash_lookup_pkg::*;
#(
  parameter int HASH_LAT   = HASH_LAT_DEF,
  parameter int RAM_LAT    = RAM_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_hash_lookup_if.slave  lk,
  output logic [63:0]       hash_a,
  input  logic [63:0]       hash_p,
  output logic [IDX_W-1:0]  ram_addr,
  output logic              ram_rd_en,
  input  logic [FP_W:0]     ram_rd_data
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]    cnt, fifo_cnt;
  logic                ready_en, accept, pop, fifo_empty;
  logic                issue_vld;
  logic [TAG_W-1:0]    issue_tag;
  logic [HASH_LAT-1:0] hv;
  logic [TAG_W-1:0]    ht [HASH_LAT];
  logic                al_vld;
  logic [TAG_W-1:0]    rd_tag;
  logic [FP_W-1:0]     rd_fp;
  logic [RAM_LAT-1:0]  dv;
  probe_t              dl [RAM_LAT];
  probe_t              cmp_p;
  lookup_res_t         cmp_res, head;

  assign lk.s_ready = ready_en && (cnt < CNT_W'(FIFO_DEPTH));
  assign accept     = lk.s_valid && lk.s_ready;
  assign pop        = lk.m_valid && lk.m_ready;
  assign al_vld     = hv[HASH_LAT-1];

  // ready_en keeps s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      cnt       <= '0;
      issue_vld <= 1'b0;
      hash_a    <= '0;
      hv        <= '0;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      dv        <= '0;
    end else begin
      ready_en  <= 1'b1;
      if (accept && !pop) cnt <= cnt + 1'b1;
      else if (!accept && pop) cnt <= cnt - 1'b1;
      issue_vld <= accept;
      if (accept) hash_a <= lk.s_key;
      hv[0] <= issue_vld;
      for (int i = 1; i < HASH_LAT; i++) hv[i] <= hv[i-1];
      ram_rd_en <= al_vld;
      if (al_vld) ram_addr <= idx_of(hash_p);
      dv[0] <= ram_rd_en;
      for (int i = 1; i < RAM_LAT; i++) dv[i] <= dv[i-1];
    end
  end

  // Payload alongside the valid pipes; only qualified by the valids above.
  always_ff @(posedge clk) begin
    if (accept) issue_tag <= lk.s_tag;
    ht[0] <= issue_tag;
    for (int i = 1; i < HASH_LAT; i++) ht[i] <= ht[i-1];
    if (al_vld) begin
      rd_tag <= ht[HASH_LAT-1];
      rd_fp  <= fp_of(hash_p);
    end
    dl[0] <= '{tag: rd_tag, idx: ram_addr, fp: rd_fp};
    for (int i = 1; i < RAM_LAT; i++) dl[i] <= dl[i-1];
  end

  assign cmp_p       = dl[RAM_LAT-1];
  assign cmp_res.tag = cmp_p.tag;
  assign cmp_res.idx = cmp_p.idx;
  assign cmp_res.hit = ram_rd_data[FP_W] && (ram_rd_data[FP_W-1:0] == cmp_p.fp);

  lookup_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (dv[RAM_LAT-1]),
    .push_dat (cmp_res),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign lk.m_valid = !fifo_empty;
  assign lk.m_tag   = head.tag;
  assign lk.m_idx   = head.idx;
  assign lk.m_hit   = head.hit;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    dv[RAM_LAT-1] |-> (fifo_cnt != CNT_W'(FIFO_DEPTH)) || pop);

endmodule

// File: tb/tb_mul_hash_lookup.sv
// Bench for mul_hash_lookup: identity hasher with 10-cycle delay, 2-cycle bucket RAM, queue-based result model.
module tb_mul_hash_lookup;
  import mul_hash_lookup_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_hash_lookup_if lk();
  logic [63:0]      hash_a, hash_p;
  logic [IDX_W-1:0] ram_addr;
  logic             ram_rd_en;
  logic [FP_W:0]    ram_rd_data;

  mul_hash_lookup dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lk          (lk),
    .hash_a      (hash_a),
    .hash_p      (hash_p),
    .ram_addr    (ram_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_data (ram_rd_data)
  );

  logic [63:0] hpipe [10];
  always @(posedge clk) begin
    hpipe[0] <= hash_a;
    for (int i = 1; i < 10; i++) hpipe[i] <= hpipe[i-1];
  end
  assign hash_p = hpipe[9];

  logic [FP_W:0] ram_mem [4096];
  logic [FP_W:0] r1, r2;
  always @(posedge clk) begin
    r1 <= ram_rd_en ? ram_mem[ram_addr] : 17'h1ffff;
    r2 <= r1;
  end
  assign ram_rd_data = r2;

  typedef struct {
    logic [15:0] tag;
    logic [11:0] idx;
    logic        hit;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, npop = 0, first_pop = -1, last_pop = 0, maxq = 0;
  logic        rdy_chk = 1'b0, prev_stall = 1'b0, mvld = 1'b0;
  logic [29:0] prev_m = '0;
  logic [15:0] last_tag = '0;
  logic [11:0] last_idx = '0;
  logic        last_hit = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] key, input logic [15:0] tag);
    exp_t          e;
    logic [FP_W:0] ent;
    e.tag = tag;
    e.idx = key[63:52];
    ent   = ram_mem[e.idx];
    e.hit = ent[16] && (ent[15:0] == key[15:0]);
    return e;
  endfunction

  // One clock: drive at the falling edge, then score the handshakes of the coming rising edge.
  task automatic step(input logic sv, input logic [63:0] key, input logic [15:0] tag,
                      input logic mr, output logic acc);
    exp_t        e;
    logic [29:0] cur;
    @(negedge clk);
    lk.s_valid = sv;
    lk.s_key   = key;
    lk.s_tag   = tag;
    lk.m_ready = mr;
    #1;
    cyc++;
    mvld = lk.m_valid;
    cur  = {lk.m_valid, lk.m_tag, lk.m_idx, lk.m_hit};
    if (rdy_chk) chk("s_ready", lk.s_ready, q.size() < 16);
    if (prev_stall) chk("m_stable", cur, prev_m);
    prev_stall = lk.m_valid && !mr;
    prev_m     = cur;
    if (q.size() > maxq) maxq = q.size();
    acc = sv && lk.s_ready;
    if (lk.m_valid && q.size() == 0) chk("spurious_vld", lk.m_valid, 0);
    else if (lk.m_valid && mr) begin
      e = q.pop_front();
      chk("m_tag", lk.m_tag, e.tag);
      chk("m_idx", lk.m_idx, e.idx);
      chk("m_hit", lk.m_hit, e.hit);
      last_tag = lk.m_tag;
      last_idx = lk.m_idx;
      last_hit = lk.m_hit;
      npop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (acc) q.push_back(model(key, tag));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    lk.s_valid = 1'b0;
    lk.m_ready = 1'b0;
    lk.s_key   = '0;
    lk.s_tag   = '0;
    rdy_chk    = 1'b0;
    prev_stall = 1'b0;
    q.delete();
    #1;
    chk("rst_s_ready", lk.s_ready, 0);
    chk("rst_m_valid", lk.m_valid, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_hash_a", hash_a, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_m_tag", lk.m_tag, 0);
    chk("rst_m_idx", lk.m_idx, 0);
    chk("rst_m_hit", lk.m_hit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_s_ready", lk.s_ready, 0);
    @(negedge clk);
    #1 chk("up_s_ready", lk.s_ready, 1);
    rdy_chk = 1'b1;
  endtask

  task automatic drain(input string name);
    logic a;
    int   n = 0;
    while (q.size() != 0 && n < 100) begin
      step(1'b0, '0, '0, 1'b1, a);
      n++;
    end
    chk(name, q.size(), 0);
    repeat (3) step(1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic one_lookup(input string name, input logic [63:0] key, input logic [15:0] tag,
                            input logic exp_hit);
    logic a;
    int   a_cyc, lat, n;
    step(1'b1, key, tag, 1'b1, a);
    chk({name, "_acc"}, a, 1);
    a_cyc = cyc;
    lat   = -1;
    n     = 0;
    while (lat < 0 && n < 40) begin
      step(1'b0, '0, '0, 1'b1, a);
      n++;
      // An output first seen at step m was produced by the edge that closed step m-1.
      if (mvld) lat = cyc - 1 - a_cyc;
    end
    chk({name, "_lat"}, lat, 14);
    chk({name, "_tag"}, last_tag, tag);
    chk({name, "_idx"}, last_idx, key[63:52]);
    chk({name, "_hit"}, last_hit, exp_hit);
    drain({name, "_drain"});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        a;
    int          k, n;
    logic [63:0] bk [20];
    logic [11:0] idx;
    logic [15:0] fp;
    logic [63:0] key;

    lk.s_valid = 1'b0;
    lk.m_ready = 1'b0;
    lk.s_key   = '0;
    lk.s_tag   = '0;
    for (int i = 0; i < 4096; i++) ram_mem[i] = '0;

    do_reset();

    ram_mem[12'hABC] = {1'b1, 16'h1234};
    one_lookup("hit", 64'hABC0_0000_0000_1234, 16'd7, 1'b1);
    ram_mem[12'hABC] = {1'b0, 16'h1234};
    one_lookup("miss_inv", 64'hABC0_0000_0000_1234, 16'd8, 1'b0);
    ram_mem[12'hABC] = {1'b1, 16'h1235};
    one_lookup("miss_fp", 64'hABC0_0000_0000_1234, 16'd9, 1'b0);

    for (int i = 0; i < 4096; i++) ram_mem[i] = 17'($urandom);

    // Backpressure: only 16 credits, then a pop and an offered key in the same cycle.
    for (int i = 0; i < 20; i++) bk[i] = {$urandom, $urandom};
    k = 0;
    for (int c = 0; c < 20; c++) begin
      step(k < 20, bk[k], 16'(100 + k), 1'b0, a);
      if (a) k++;
    end
    chk("bp_acc", k, 16);
    chk("bp_rdy_low", lk.s_ready, 0);
    repeat (15) step(1'b1, bk[k], 16'(100 + k), 1'b0, a);
    chk("bp_full_vld", lk.m_valid, 1);
    step(1'b1, bk[k], 16'(100 + k), 1'b1, a);
    chk("sim_noacc", a, 0);
    step(1'b1, bk[k], 16'(100 + k), 1'b0, a);
    chk("sim_rdy", lk.s_ready, 1);
    chk("sim_acc", a, 1);
    if (a) k++;
    step(1'b1, bk[k], 16'(100 + k), 1'b0, a);
    chk("sim_full", lk.s_ready, 0);
    n = 0;
    while ((k < 20 || q.size() != 0) && n < 200) begin
      step(k < 20, bk[k < 20 ? k : 19], 16'(100 + k), 1'b1, a);
      if (a) k++;
      n++;
    end
    chk("bp_all", k, 20);
    drain("bp_drain");

    // Streaming at full rate.
    npop      = 0;
    first_pop = -1;
    maxq      = 0;
    for (int i = 0; i < 100; i++) begin
      idx = 12'($urandom_range(0, 4095));
      fp  = ($urandom_range(0, 1) == 1) ? ram_mem[idx][15:0] : 16'($urandom);
      key = {idx, 36'({$urandom, $urandom}), fp};
      step(1'b1, key, 16'(1000 + i), 1'b1, a);
      chk("stream_acc", a, 1);
    end
    drain("stream_drain");
    chk("stream_n", npop, 100);
    chk("stream_span", last_pop - first_pop, 99);
    chk("stream_maxq", maxq < 16, 1);

    // Reset with lookups in flight.
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 16'(200 + i), 1'b1, a);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, '0, 1'b1, a);
      chk("rst_quiet", mvld, 0);
    end
    ram_mem[12'h123] = {1'b1, 16'hBEEF};
    one_lookup("post_rst", 64'h1230_0000_0000_BEEF, 16'h0055, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
